// File: rtl/labs_pkg.sv
// Shared types and width helpers for the LABS merit engine.
package labs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Bits needed for the worst-case energy, reached by a constant sequence.
    function automatic int energy_width(input int n);
        return $clog2((n - 1) * n * (2 * n - 1) / 6 + 1);
    endfunction

    // Bits needed for max |C_k|, which never exceeds N-1.
    function automatic int peak_width(input int n);
        return $clog2(n);
    endfunction

    // Number of lag groups when P lags are evaluated per cycle.
    function automatic int num_groups(input int n, input int p);
        return (n - 1 + p - 1) / p;
    endfunction

    // Width of the group counter; at least one bit even for a single group.
    function automatic int group_width(input int n, input int p);
        return (num_groups(n, p) > 1) ? $clog2(num_groups(n, p)) : 1;
    endfunction

    // Width of a lane's lag index; the last group can address up to G*P.
    function automatic int lag_width(input int n, input int p);
        return $clog2(num_groups(n, p) * p + 1);
    endfunction

endpackage

// File: rtl/ck_lag_unit.sv
// Combinational aperiodic autocorrelation term C_k for a single lag k.
module ck_lag_unit
    import labs_pkg::*;
#(
    parameter int N  = 40,
    parameter int KW = 6,
    localparam int AW = peak_width(N),
    localparam int CW = AW + 1
) (
    input  logic [N-1:0]         i_seq,
    input  logic [KW-1:0]        i_k,
    output logic signed [CW-1:0] o_ck,
    output logic [AW-1:0]        o_abs
);

    logic [N-1:0] w_shifted;
    logic [N-1:0] w_diff;
    int           w_len;
    int           w_pop;
    int           w_ck;

    assign w_shifted = i_seq >> i_k;
    assign w_diff    = i_seq ^ w_shifted;

    // Count disagreeing pairs inside the overlap window; each disagreement
    // turns a +1 product into -1, so C_k = overlap - 2*disagreements.
    // A lag of zero or beyond the sequence yields a zero term.
    always_comb begin
        w_len = N - int'(i_k);
        w_pop = 0;
        for (int i = 0; i < N; i++) begin
            if ((i < w_len) && w_diff[i]) begin
                w_pop = w_pop + 1;
            end
        end
        w_ck = w_len - 2 * w_pop;
        if ((i_k == '0) || (w_len <= 0)) begin
            w_ck = 0;
        end
        o_ck  = CW'(w_ck);
        o_abs = AW'((w_ck < 0) ? -w_ck : w_ck);
    end

endmodule

// File: rtl/labs_energy_seq.sv
// Iterative LABS merit engine: sidelobe energy and peak over all lags,
// evaluated LAGS_PER_CYCLE lags at a time.
module labs_energy_seq
    import labs_pkg::*;
#(
    parameter int SEQ_WIDTH      = 40,
    parameter int LAGS_PER_CYCLE = 4,
    localparam int ENERGY_W      = energy_width(SEQ_WIDTH),
    localparam int PEAK_W        = peak_width(SEQ_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [SEQ_WIDTH-1:0] s_seq,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [ENERGY_W-1:0]  m_energy,
    output logic [PEAK_W-1:0]    m_peak
);

    localparam int N  = SEQ_WIDTH;
    localparam int P  = LAGS_PER_CYCLE;
    localparam int G  = num_groups(N, P);
    localparam int KW = lag_width(N, P);
    localparam int GW = group_width(N, P);

    state_t              r_state;
    logic [N-1:0]        r_seq;
    logic [GW-1:0]       r_group;
    logic [ENERGY_W-1:0] r_acc;
    logic [PEAK_W-1:0]   r_peak;
    logic                r_mValid;

    logic [KW-1:0]        w_laneK [P];
    logic                 w_laneValid [P];
    logic [PEAK_W-1:0]    w_laneAbs [P];
    logic signed [PEAK_W:0] w_unusedLaneCk [P];
    logic [ENERGY_W-1:0]  w_groupSq;
    logic [PEAK_W-1:0]    w_groupPeak;
    logic                 w_lastGroup;

    // Lane j of group g evaluates lag 1+gP+j; lanes past N-1 are masked off.
    // The signed terms are not needed for the merit figures themselves.
    for (genvar j = 0; j < P; j++) begin : g_lane
        assign w_laneK[j]     = KW'(int'(r_group) * P + j + 1);
        assign w_laneValid[j] = (int'(r_group) * P + j + 1) <= (N - 1);

        ck_lag_unit #(
            .N  (N),
            .KW (KW)
        ) u_lag (
            .i_seq (r_seq),
            .i_k   (w_laneK[j]),
            .o_ck  (w_unusedLaneCk[j]),
            .o_abs (w_laneAbs[j])
        );
    end

    assign w_lastGroup = (r_group == GW'(G - 1));

    // Reduce the active lanes of this group to a sum of squares and a peak.
    always_comb begin
        w_groupSq   = '0;
        w_groupPeak = '0;
        for (int j = 0; j < P; j++) begin
            if (w_laneValid[j]) begin
                w_groupSq = w_groupSq + ENERGY_W'(w_laneAbs[j]) * ENERGY_W'(w_laneAbs[j]);
                if (w_laneAbs[j] > w_groupPeak) begin
                    w_groupPeak = w_laneAbs[j];
                end
            end
        end
    end

    // Control FSM: capture a sequence, accumulate one group per cycle, then
    // hold the result until the consumer takes it (optionally back-to-back).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_seq    <= '0;
            r_group  <= '0;
            r_acc    <= '0;
            r_peak   <= '0;
            r_mValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_valid) begin
                        r_seq    <= s_seq;
                        r_group  <= '0;
                        r_acc    <= '0;
                        r_peak   <= '0;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_acc <= r_acc + w_groupSq;
                    if (w_groupPeak > r_peak) begin
                        r_peak <= w_groupPeak;
                    end
                    if (w_lastGroup) begin
                        r_group  <= '0;
                        r_mValid <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_group <= r_group + GW'(1);
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        r_mValid <= 1'b0;
                        if (s_valid) begin
                            r_seq   <= s_seq;
                            r_group <= '0;
                            r_acc   <= '0;
                            r_peak  <= '0;
                            r_state <= CALC;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_ready  = (r_state == IDLE) | ((r_state == DONE) & m_ready);
    assign m_valid  = r_mValid;
    assign m_energy = r_acc;
    assign m_peak   = r_peak;

endmodule

// File: tb/tb_labs_energy_seq.sv
// Scoreboard bench for labs_energy_seq across several (N, P) configurations.
module tb_labs_energy_seq;

    localparam int NCFG  = 6;
    localparam int NRAND = 250;

    localparam int CFG_N [NCFG] = '{7, 8, 40, 13, 13, 64};
    localparam int CFG_P [NCFG] = '{2, 3, 4, 1, 12, 7};

    // First directed sequence: Barker-7 for N=7, all-ones elsewhere.
    localparam logic [63:0] DIR_S1 [NCFG] = '{
        64'h0000_0000_0000_0027, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
        64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    localparam int DIR_E1 [NCFG] = '{3, 140, 20540, 650, 650, 85344};
    localparam int DIR_P1 [NCFG] = '{1, 7, 39, 12, 12, 63};
    // Second directed sequence: alternating pattern.
    localparam logic [63:0] DIR_S2 = 64'h5555_5555_5555_5555;
    localparam int DIR_E2 [NCFG] = '{91, 140, 20540, 650, 650, 85344};
    localparam int DIR_P2 [NCFG] = '{6, 7, 39, 12, 12, 63};

    logic clk = 1'b0;
    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int cfg, input longint actual, input longint expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL cfg%0d %s: got %0d, expected %0d", cfg, name, actual, expected);
        end
    endtask

    task automatic reportError(input string name, input int cfg);
        nChecks++;
        nFails++;
        $display("[TB] FAIL cfg%0d %s: bound expired or unexpected event", cfg, name);
    endtask

    // Closed-form energy of a constant (or alternating) sequence.
    function automatic int sumSq(input int n);
        return (n - 1) * n * (2 * n - 1) / 6;
    endfunction

    // Reference: correlate the +/-1 sequence directly as sums of products.
    function automatic void refModel(input logic [63:0] seq, input int n, output int e, output int p);
        int c;
        int a;
        e = 0;
        p = 0;
        for (int k = 1; k < n; k++) begin
            c = 0;
            for (int i = 0; i + k < n; i++) begin
                c += (seq[i] == seq[i + k]) ? 1 : -1;
            end
            a = (c < 0) ? -c : c;
            e += c * c;
            if (a > p) p = a;
        end
    endfunction

    for (genvar c = 0; c < NCFG; c++) begin : g_cfg
        localparam int N  = CFG_N[c];
        localparam int P  = CFG_P[c];
        localparam int G  = (N - 1 + P - 1) / P;
        localparam int EW = $clog2((N - 1) * N * (2 * N - 1) / 6 + 1);
        localparam int PW = $clog2(N);

        logic          rst_n;
        logic          s_valid;
        logic          s_ready;
        logic [N-1:0]  s_seq;
        logic          m_valid;
        logic          m_ready;
        logic [EW-1:0] m_energy;
        logic [PW-1:0] m_peak;
        logic          dirReady;
        logic          randReady;
        logic          rdyRand;
        bit            done = 1'b0;

        int expE [$];
        int expP [$];
        int expLat [$];

        bit            prevValid = 1'b0;
        bit            prevHold = 1'b0;
        logic [EW-1:0] prevEnergy;
        logic [PW-1:0] prevPeak;

        assign m_ready = randReady ? rdyRand : dirReady;

        labs_energy_seq #(
            .SEQ_WIDTH      (N),
            .LAGS_PER_CYCLE (P)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .s_valid  (s_valid),
            .s_ready  (s_ready),
            .s_seq    (s_seq),
            .m_valid  (m_valid),
            .m_ready  (m_ready),
            .m_energy (m_energy),
            .m_peak   (m_peak)
        );

        // Offer one sequence until accepted; queue its expectation if tracked.
        task automatic applyStimulus(input logic [63:0] seq, input int e, input int p,
                                     input bit track, output int acceptEdge);
            int n;
            n = 0;
            s_seq   = seq[N-1:0];
            s_valid = 1'b1;
            @(negedge clk);
            while (!s_ready && (n < 1000)) begin
                @(negedge clk);
                n++;
            end
            if (!s_ready) begin
                reportError("accept timeout", c);
                acceptEdge = -1;
            end else begin
                acceptEdge = cyc + 1;
                if (track) begin
                    expE.push_back(e);
                    expP.push_back(p);
                    expLat.push_back(acceptEdge);
                end
            end
            @(posedge clk);
            #1;
            s_valid = 1'b0;
        endtask

        task automatic waitDrain();
            int n;
            n = 0;
            dirReady = 1'b1;
            while ((expE.size() != 0) && (n < 2000)) begin
                @(posedge clk);
                n++;
            end
            if (expE.size() != 0) reportError("drain timeout", c);
            @(posedge clk);
            #1;
        endtask

        initial begin
            rdyRand = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                rdyRand = ($urandom_range(0, 3) != 0);
            end
        end

        // Monitor: results, hold stability under backpressure, and latency.
        always @(negedge clk) begin
            if (rst_n === 1'b1) begin
                if (prevHold) begin
                    checkOutput("hold m_valid", c, m_valid, 1);
                    checkOutput("hold m_energy", c, m_energy, prevEnergy);
                    checkOutput("hold m_peak", c, m_peak, prevPeak);
                end
                if (m_valid && !prevValid) begin
                    if (expLat.size() == 0) reportError("unexpected m_valid", c);
                    else checkOutput("latency", c, cyc - expLat.pop_front(), G);
                end
                if (m_valid && m_ready) begin
                    if (expE.size() == 0) begin
                        reportError("unexpected result", c);
                    end else begin
                        checkOutput("m_energy", c, m_energy, expE.pop_front());
                        checkOutput("m_peak", c, m_peak, expP.pop_front());
                    end
                end
            end
            prevValid  <= m_valid;
            prevHold   <= (rst_n === 1'b1) && m_valid && !m_ready;
            prevEnergy <= m_energy;
            prevPeak   <= m_peak;
        end

        initial begin : drive
            int accA;
            int accB;
            int raiseEdge;
            int nWait;
            int e;
            int p;
            int e2;
            int p2;
            logic [63:0] seq;
            logic [63:0] seq2;

            rst_n     = 1'b0;
            s_valid   = 1'b0;
            s_seq     = '0;
            dirReady  = 1'b0;
            randReady = 1'b0;

            #12;
            checkOutput("reset m_valid", c, m_valid, 0);
            checkOutput("reset m_energy", c, m_energy, 0);
            checkOutput("reset m_peak", c, m_peak, 0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(negedge clk);
            checkOutput("s_ready after reset", c, s_ready, 1);

            // Directed pair, back-to-back with the consumer always ready.
            @(posedge clk);
            #1;
            dirReady = 1'b1;
            applyStimulus(DIR_S1[c], DIR_E1[c], DIR_P1[c], 1'b1, accA);
            applyStimulus(DIR_S2, DIR_E2[c], DIR_P2[c], 1'b1, accB);
            checkOutput("back-to-back spacing", c, accB - accA, G + 1);
            waitDrain();

            // Backpressure: result must hold and new input must be refused.
            dirReady = 1'b0;
            seq = {$urandom, $urandom};
            refModel(seq, N, e, p);
            applyStimulus(seq, e, p, 1'b1, accA);
            nWait = 0;
            while (!m_valid && (nWait < 1000)) begin
                @(negedge clk);
                nWait++;
            end
            if (!m_valid) reportError("bp m_valid timeout", c);
            seq2 = {$urandom, $urandom};
            refModel(seq2, N, e2, p2);
            s_seq   = seq2[N-1:0];
            s_valid = 1'b1;
            repeat (5) begin
                @(negedge clk);
                checkOutput("bp s_ready", c, s_ready, 0);
                checkOutput("bp m_valid", c, m_valid, 1);
                checkOutput("bp m_energy", c, m_energy, e);
                checkOutput("bp m_peak", c, m_peak, p);
            end
            @(posedge clk);
            #1;
            dirReady  = 1'b1;
            raiseEdge = cyc;
            applyStimulus(seq2, e2, p2, 1'b1, accB);
            checkOutput("bp same-cycle accept", c, accB, raiseEdge + 1);
            waitDrain();

            // Reset during computation abandons the sequence silently.
            applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1'b0, accA);
            repeat ((G > 2) ? 2 : G - 1) @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            checkOutput("rst m_valid", c, m_valid, 0);
            checkOutput("rst m_energy", c, m_energy, 0);
            checkOutput("rst m_peak", c, m_peak, 0);
            @(posedge clk);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(negedge clk);
            checkOutput("rst s_ready", c, s_ready, 1);
            @(posedge clk);
            #1;
            applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, sumSq(N), N - 1, 1'b1, accA);
            waitDrain();

            // Random regression with random input gaps and consumer stalls.
            randReady = 1'b1;
            for (int n = 0; n < NRAND; n++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                seq = {$urandom, $urandom};
                refModel(seq, N, e, p);
                applyStimulus(seq, e, p, 1'b1, accA);
            end
            randReady = 1'b0;
            waitDrain();
            done = 1'b1;
        end
    end

    initial begin : finisher
        int n;
        n = 0;
        while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done &&
                 g_cfg[3].done && g_cfg[4].done && g_cfg[5].done) && (n < 90000)) begin
            @(posedge clk);
            n++;
        end
        if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done &&
              g_cfg[3].done && g_cfg[4].done && g_cfg[5].done)) begin
            reportError("global timeout", -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/labs_energy_seq.md
# labs_energy_seq

Iterative LABS merit engine: accepts one ±1 binary sequence of SEQ_WIDTH bits over a valid/ready handshake and computes the aperiodic autocorrelations C_k for every lag k = 1..SEQ_WIDTH-1. It returns the sidelobe energy E = Σ C_k² and the peak sidelobe max|C_k|. It is the multi-lag, multi-cycle successor of the single-lag C_k datapath. It sits between the sequence generator/search walker and the best-candidate tracker. LAGS_PER_CYCLE trades area for latency.

## Interface
- SEQ_WIDTH, 40: sequence length N; legal range 3..64.
- LAGS_PER_CYCLE, 4: lags P evaluated per cycle; legal range 1..N-1.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- s_valid  in  1  input sequence valid.
- s_ready  out  1  engine can accept a sequence.
- s_seq  in  SEQ_WIDTH  bit i = element s_i; 1 → +1, 0 → −1.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_energy  out  ENERGY_W  E = Σ_{k=1}^{N-1} C_k².
- m_peak  out  PEAK_W  max_{k≥1} |C_k|.

## Operation
- Lag term: C_k = (N−k) − 2·popcount(s[0 +: N−k] XOR s[k +: N−k]). Signed, |C_k| ≤ N−k.
- Lags are processed in G = ceil((N−1)/P) groups. Group g covers k = 1+gP .. min(gP+P, N−1). The final group may be partial; unused lanes contribute 0 to energy and peak.
- FSM states: IDLE, CALC, DONE.
  - IDLE: s_ready=1. s_valid&s_ready → capture s_seq, clear acc and peak, g=0, go to CALC.
  - CALC: each cycle acc += Σ group squares; peak = max(peak, group |C_k|); g++. After group G−1 is added, go to DONE.
  - DONE: m_valid=1; m_energy/m_peak hold acc/peak. If m_ready and s_valid, capture the new sequence and go to CALC (back-to-back). If m_ready and !s_valid, go to IDLE. If !m_ready, hold: outputs stable, s_ready=0.
- s_ready = (state==IDLE) | (state==DONE & m_ready). s_seq is ignored outside an accepting handshake.
- Width rules:
  - ENERGY_W = clog2((N−1)N(2N−1)/6 + 1).
  - PEAK_W = clog2(N).
  - Accumulation never wraps.
  - Squares use the absolute value.
- Reset values: state=IDLE, s_ready=1 (after reset release), m_valid=0, m_energy=0, m_peak=0, internal acc/peak/g=0.
- Reset asserted mid-CALC or in DONE: computation is abandoned immediately with no partial result emitted.

## Timing
- Handshake accepted at edge 0. Groups are accumulated at edges 1..G. m_valid is high after edge G; latency is G cycles.
- Defaults (N=40, P=4): G=10.
- Sustained throughput with m_ready held high: one sequence per G+1 cycles.
- m_valid, once high, stays high with stable data until m_ready is sampled high.
- There is no combinational path from s_valid or m_ready to m_valid. The m_ready→s_ready path is permitted (one gate).

## Structure
- Shared package labs_pkg:
  - functions energy_width(N), peak_width(N), num_groups(N,P);
  - typedef for the state enum (IDLE/CALC/DONE).
- Sub-module ck_lag_unit: combinational unit (parameter N), taking the sequence and a lag k and returning signed C_k and |C_k|. It is instantiated P times in a generate loop. Lane j is driven with k = 1+gP+j and masked when k > N−1.
- Top module contains the FSM, group counter, accumulator, peak register and output handshake.

## Test plan
- N=7, P=2, s_seq=7'h27 (Barker-7) → m_energy=3, m_peak=1, m_valid exactly 3 cycles after accept.
- N=8, P=3, s_seq=8'hFF → m_energy=140, m_peak=7. Repeat with 8'h55 (alternating) → m_energy=140, m_peak=7. G=3; the last group is partial (k=7 only).
- Defaults N=40, P=4, all-ones → m_energy=20540 (15-bit, no overflow), m_peak=39, latency 10.
- Backpressure: hold m_ready=0 for 5 cycles in DONE → outputs stable, s_ready=0, the next s_valid is not accepted. Then raise m_ready together with s_valid → new sequence accepted in the same cycle, and the next result arrives G cycles later.
- Reset mid-CALC: deassert rst_n at group 2 of 10 → m_valid=0 and outputs 0 asynchronously. After release, s_ready=1 and a fresh all-ones sequence gives 20540.
- Random regression: 1000 random sequences for (N,P) ∈ {(40,4),(13,1),(13,12),(64,7)} against a reference model of E and peak, with random s_valid/m_ready gaps.
